// File: rtl/cpaep_loader_pkg.sv
// Shared types and field widths for the tile load sequencer.
// Included first; imported by the counter and the sequencer top.
package cpaep_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_KERNEL,
        LD_INPUT,
        LD_OVL,
        WAIT_CORE,
        READY
    } load_state_t;

    localparam int KERNEL_SEL_BIT = 15;
    localparam int KADDR_W        = 9;
    localparam int IADDR_W        = 14;
    localparam int OADDR_W        = 8;
    localparam int CNT_W          = 14;

endpackage

// File: rtl/tile_load_sequencer_counter.sv
// Phase word counter shared by the kernel, input and overlap phases.
// Wraps to zero on the terminal accept so the next phase starts at 0.
module load_phase_counter
    import cpaep_loader_pkg::*;
(
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tile_load_sequencer.sv
// Turns one host word stream per tile into kernel, input and overlap
// write strobes for the core, then holds data_ready until fsm_done.
module tile_load_sequencer
    import cpaep_loader_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16,
    parameter int KERNEL_WORDS  = 512,
    parameter int INPUT_WORDS   = 16384,
    parameter int OVERLAP_WORDS = 256
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start_load,
    input  logic                     skip_kernel,
    input  logic [IO_DATA_WIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [IO_DATA_WIDTH-1:0] a_input,
    output logic [IO_DATA_WIDTH-1:0] b_input,
    output logic                     int_mem_we,
    output logic                     overlap_cache_we,
    output logic                     data_ready,
    input  logic                     fsm_done,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] K_LIM = CNT_W'(KERNEL_WORDS - 1);
    localparam logic [CNT_W-1:0] I_LIM = CNT_W'(INPUT_WORDS - 1);
    localparam logic [CNT_W-1:0] O_LIM = CNT_W'(OVERLAP_WORDS - 1);

    load_state_t state_q, state_d;

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         limit;
    logic                     last;
    logic                     accept;
    logic [IO_DATA_WIDTH-1:0] a_q, a_d;
    logic [IO_DATA_WIDTH-1:0] b_q, b_d;
    logic                     imw_q, imw_d;
    logic                     ocw_q, ocw_d;

    // Ready depends on state only so the host never sees a valid->ready loop.
    assign in_ready = (state_q == LD_KERNEL) ||
                      (state_q == LD_INPUT)  ||
                      (state_q == LD_OVL);
    assign accept   = in_valid && in_ready;

    assign a_input          = a_q;
    assign b_input          = b_q;
    assign int_mem_we       = imw_q;
    assign overlap_cache_we = ocw_q;
    assign data_ready       = (state_q == READY);
    assign busy             = (state_q != IDLE);

    always_comb begin
        limit = '0;
        unique case (state_q)
            LD_KERNEL: limit = K_LIM;
            LD_INPUT:  limit = I_LIM;
            LD_OVL:    limit = O_LIM;
            default:   limit = '0;
        endcase
    end

    load_phase_counter u_cnt (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .clr_i    (state_q == IDLE),
        .en_i     (accept),
        .limit_i  (limit),
        .cnt_o    (cnt),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_load) state_d = skip_kernel ? LD_INPUT : LD_KERNEL;
            LD_KERNEL: if (accept && last) state_d = LD_INPUT;
            LD_INPUT:  if (accept && last) state_d = LD_OVL;
            LD_OVL:    if (accept && last) state_d = WAIT_CORE;
            WAIT_CORE: state_d = READY;
            READY:     if (fsm_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        imw_d = 1'b0;
        ocw_d = 1'b0;
        if (accept) begin
            a_d = '0;
            b_d = in_data;
            unique case (state_q)
                LD_KERNEL: begin
                    a_d[KERNEL_SEL_BIT] = 1'b1;
                    a_d[KADDR_W-1:0]    = cnt[KADDR_W-1:0];
                    imw_d               = 1'b1;
                end
                LD_INPUT: begin
                    a_d[IADDR_W-1:0] = cnt[IADDR_W-1:0];
                    imw_d            = 1'b1;
                end
                default: begin
                    a_d[OADDR_W-1:0] = cnt[OADDR_W-1:0];
                    ocw_d            = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            imw_q   <= 1'b0;
            ocw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imw_q   <= imw_d;
            ocw_q   <= ocw_d;
        end
    end

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Self-checking bench: directed steps with randomized host stream checked
// against an index-based model of the expected write sequence.
module tb_tile_load_sequencer;

    localparam int KW = 512;
    localparam int IW = 16384;
    localparam int OW = 256;

    logic        clk = 1'b0;
    logic        arst_n_in = 1'b0;
    logic        start_load = 1'b0;
    logic        skip_kernel = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_input;
    logic [15:0] b_input;
    logic        int_mem_we;
    logic        overlap_cache_we;
    logic        data_ready;
    logic        fsm_done = 1'b0;
    logic        busy;

    logic        s_start = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_imw;
    logic        s_ocw;
    logic        s_dr;
    logic        s_done = 1'b0;
    logic        s_busy;

    int checks = 0;
    int failures = 0;
    logic [15:0] sent[$];
    logic [15:0] last_a;
    logic [15:0] last_b;

    always #5 clk = ~clk;

    tile_load_sequencer dut (
        .clk             (clk),
        .arst_n_in       (arst_n_in),
        .start_load      (start_load),
        .skip_kernel     (skip_kernel),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a_input         (a_input),
        .b_input         (b_input),
        .int_mem_we      (int_mem_we),
        .overlap_cache_we(overlap_cache_we),
        .data_ready      (data_ready),
        .fsm_done        (fsm_done),
        .busy            (busy)
    );

    tile_load_sequencer #(
        .KERNEL_WORDS (1),
        .INPUT_WORDS  (1),
        .OVERLAP_WORDS(1)
    ) dut_s (
        .clk             (clk),
        .arst_n_in       (arst_n_in),
        .start_load      (s_start),
        .skip_kernel     (1'b0),
        .in_data         (s_data),
        .in_valid        (s_valid),
        .in_ready        (s_ready),
        .a_input         (s_a),
        .b_input         (s_b),
        .int_mem_we      (s_imw),
        .overlap_cache_we(s_ocw),
        .data_ready      (s_dr),
        .fsm_done        (s_done),
        .busy            (s_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // 0 = kernel, 1 = input, 2 = overlap for the i-th word of a tile
    function automatic int kind_of(input bit skip, input int i);
        int k = skip ? 0 : KW;
        if (i < k) return 0;
        if (i < k + IW) return 1;
        return 2;
    endfunction

    function automatic logic [15:0] exp_addr(input bit skip, input int i);
        int k = skip ? 0 : KW;
        if (i < k) return 16'h8000 + 16'(i);
        if (i < k + IW) return 16'(i - k);
        return 16'(i - k - IW);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".a"}, a_input, 16'h0000);
        chk({tag, ".b"}, b_input, 16'h0000);
        chk1({tag, ".imw"}, int_mem_we, 1'b0);
        chk1({tag, ".ocw"}, overlap_cache_we, 1'b0);
        chk1({tag, ".rdy"}, in_ready, 1'b0);
        chk1({tag, ".dr"}, data_ready, 1'b0);
        chk1({tag, ".busy"}, busy, 1'b0);
    endtask

    task automatic run_tile(input bit skip, input int duty, input int abort_at);
        int  n = (skip ? 0 : KW) + IW + OW;
        int  acc = 0;
        int  cyc = 0;
        bit  prev = 0;
        int  k;
        sent.delete();
        @(negedge clk);
        start_load  = 1'b1;
        skip_kernel = skip;
        in_valid    = 1'b0;
        @(negedge clk);
        start_load  = 1'b0;
        skip_kernel = 1'b0;
        forever begin
            chk1("in_ready", in_ready, acc < n);
            chk1("busy", busy, 1'b1);
            chk1("data_ready_early", data_ready, 1'b0);
            if (prev) begin
                k = kind_of(skip, acc - 1);
                chk1("int_we", int_mem_we, k != 2);
                chk1("ovl_we", overlap_cache_we, k == 2);
                chk("addr", a_input, exp_addr(skip, acc - 1));
                chk("data", b_input, sent[acc - 1]);
            end else begin
                chk1("int_we_idle", int_mem_we, 1'b0);
                chk1("ovl_we_idle", overlap_cache_we, 1'b0);
            end
            if (abort_at >= 0 && acc == abort_at) begin
                arst_n_in = 1'b0;
                in_valid  = 1'b1;
                #1;
                chk_reset_outputs("abort");
                @(negedge clk);
                arst_n_in = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk1("post_abort_imw", int_mem_we, 1'b0);
                    chk1("post_abort_ocw", overlap_cache_we, 1'b0);
                    chk1("post_abort_rdy", in_ready, 1'b0);
                    chk1("post_abort_busy", busy, 1'b0);
                end
                in_valid = 1'b0;
                return;
            end
            in_valid = ($urandom_range(0, 99) < duty);
            in_data  = 16'($urandom);
            prev = in_valid && (acc < n);
            if (prev) begin
                sent.push_back(in_data);
                acc++;
            end
            if (!prev && acc == n) begin
                in_valid = 1'b0;
                break;
            end
            cyc++;
            if (cyc > 40 * n) begin
                checks++;
                failures++;
                $error("FAIL tile_timeout accepted=%0d required=%0d", acc, n);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk1("data_ready_set", data_ready, 1'b1);
        chk1("ready_rdy", in_ready, 1'b0);
        chk1("ready_busy", busy, 1'b1);
        chk1("ready_imw", int_mem_we, 1'b0);
        chk1("ready_ocw", overlap_cache_we, 1'b0);
        last_a = exp_addr(skip, n - 1);
        last_b = (sent.size() > 0) ? sent[sent.size() - 1] : 16'h0000;
    endtask

    initial begin
        #12;
        chk_reset_outputs("reset");
        chk1("s_reset_rdy", s_ready, 1'b0);
        chk1("s_reset_dr", s_dr, 1'b0);
        @(negedge clk);
        arst_n_in = 1'b1;

        // minimal phases: three strobes back to back, then data_ready
        @(negedge clk);
        s_start = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hA000;
        @(negedge clk);
        s_start = 1'b0;
        chk1("s_rdy", s_ready, 1'b1);
        chk1("s_no_we", s_imw | s_ocw, 1'b0);
        s_data = 16'hA001;
        @(negedge clk);
        chk1("s_k_imw", s_imw, 1'b1);
        chk("s_k_a", s_a, 16'h8000);
        chk("s_k_b", s_b, 16'hA001);
        s_data = 16'hA002;
        @(negedge clk);
        chk1("s_i_imw", s_imw, 1'b1);
        chk1("s_i_ocw", s_ocw, 1'b0);
        chk("s_i_a", s_a, 16'h0000);
        chk("s_i_b", s_b, 16'hA002);
        s_data = 16'hA003;
        @(negedge clk);
        chk1("s_o_ocw", s_ocw, 1'b1);
        chk1("s_o_imw", s_imw, 1'b0);
        chk("s_o_a", s_a, 16'h0000);
        chk("s_o_b", s_b, 16'hA003);
        chk1("s_o_dr", s_dr, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        chk1("s_dr", s_dr, 1'b1);
        chk1("s_dr_rdy", s_ready, 1'b0);
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        chk1("s_done_dr", s_dr, 1'b0);
        chk1("s_done_busy", s_busy, 1'b0);

        // full tile, host always valid
        run_tile(1'b0, 100, -1);

        // READY held; start_load ignored, fsm_done wins over start
        for (int c = 0; c < 100; c++) begin
            start_load = (c % 10 == 3);
            in_valid   = c[0];
            @(negedge clk);
            chk1("hold_dr", data_ready, 1'b1);
            chk1("hold_rdy", in_ready, 1'b0);
            chk1("hold_busy", busy, 1'b1);
            chk1("hold_imw", int_mem_we, 1'b0);
            chk1("hold_ocw", overlap_cache_we, 1'b0);
            chk("hold_a", a_input, last_a);
            chk("hold_b", b_input, last_b);
        end
        start_load = 1'b1;
        fsm_done   = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        fsm_done   = 1'b0;
        chk1("done_dr", data_ready, 1'b0);
        chk1("done_busy", busy, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_rdy", in_ready, 1'b0);
            chk1("idle_imw", int_mem_we, 1'b0);
            fsm_done = (c == 2);
        end
        fsm_done = 1'b0;
        in_valid = 1'b0;

        // skip kernel, abandoned by reset at input word 700
        run_tile(1'b1, 100, 700);
        // kernel tile abandoned at input word 700
        run_tile(1'b0, 100, KW + 700);
        // restart from kernel 0x8000 with a sparse host stream
        run_tile(1'b0, 30, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
